// File: rtl/ttt_grid_manager.sv
// ttt_grid_manager: game-logic core for a DIM x DIM tic-tac-toe board with a
// WIN_LEN-in-a-row rule. It tracks the cursor, the two player grids, turn and
// outcome state, and the saturating per-session game and win counters.
//
// Ports
//   clk, rst                      system clock; asynchronous active-low reset
//   btn_s/u/d/l/r                 single-cycle button pulses (place, up, down, left, right)
//   cursor_x, cursor_y            cursor coordinates, 0..DIM-1
//   p1_grid, p2_grid              player marks, bit index = y*DIM+x
//   game_state                    0 P1 turn, 1 P2 turn, 2 draw, 3 P1 wins, 4 P2 wins
//   busy                          high while the 4-cycle win check runs
//   games_played, p1_wins, p2_wins saturating 8-bit counters
module ttt_grid_manager #(
  parameter int unsigned DIM     = 3,
  parameter int unsigned WIN_LEN = 3,
  parameter int unsigned CW      = $clog2(DIM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_s,
  input  logic               btn_u,
  input  logic               btn_d,
  input  logic               btn_l,
  input  logic               btn_r,
  output logic [CW-1:0]      cursor_x,
  output logic [CW-1:0]      cursor_y,
  output logic [DIM*DIM-1:0] p1_grid,
  output logic [DIM*DIM-1:0] p2_grid,
  output logic [2:0]         game_state,
  output logic               busy,
  output logic [7:0]         games_played,
  output logic [7:0]         p1_wins,
  output logic [7:0]         p2_wins
);

  localparam int unsigned NCELL = DIM * DIM;
  localparam int unsigned IW    = $clog2(NCELL);
  localparam logic [CW-1:0] MAXC = CW'(DIM - 1);

  typedef enum logic [1:0] {StPlay, StCheck, StOver} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cx_q, cx_d, cy_q, cy_d;
  logic [NCELL-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [2:0]       gs_q, gs_d;
  logic [1:0]       dir_q, dir_d;
  logic             win_q, win_d;
  logic             starter_q, starter_d;  // 0: P1 starts the current game
  logic [7:0]       games_q, games_d, p1w_q, p1w_d, p2w_q, p2w_d;

  logic [IW-1:0]    cur_idx;
  logic [NCELL-1:0] pg;
  logic             hit;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

  assign cur_idx = IW'(cy_q) * IW'(DIM) + IW'(cx_q);

  // Run length through the cursor cell along the direction selected by dir_q.
  // The placed cell is still under the cursor because buttons are ignored in CHECK.
  always_comb begin : run_calc
    int  dx, dy, x, y, run;
    logic go_p, go_n;
    pg = gs_q[0] ? p2_q : p1_q;
    case (dir_q)
      2'd0:    begin dx = 1; dy = 0;  end
      2'd1:    begin dx = 0; dy = 1;  end
      2'd2:    begin dx = 1; dy = 1;  end
      default: begin dx = 1; dy = -1; end
    endcase
    run  = 1;
    go_p = 1'b1;
    go_n = 1'b1;
    for (int k = 1; k < int'(WIN_LEN); k++) begin
      x = int'(cx_q) + k * dx;
      y = int'(cy_q) + k * dy;
      if (go_p && x >= 0 && x < int'(DIM) && y >= 0 && y < int'(DIM)
          && pg[IW'(y * int'(DIM) + x)]) begin
        run = run + 1;
      end else begin
        go_p = 1'b0;
      end
      x = int'(cx_q) - k * dx;
      y = int'(cy_q) - k * dy;
      if (go_n && x >= 0 && x < int'(DIM) && y >= 0 && y < int'(DIM)
          && pg[IW'(y * int'(DIM) + x)]) begin
        run = run + 1;
      end else begin
        go_n = 1'b0;
      end
    end
    hit = (run >= int'(WIN_LEN));
  end

  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    gs_d      = gs_q;
    dir_d     = dir_q;
    win_d     = win_q;
    starter_d = starter_q;
    games_d   = games_q;
    p1w_d     = p1w_q;
    p2w_d     = p2w_q;
    case (state_q)
      StPlay: begin
        if (btn_s) begin
          // An occupied cell swallows the press; lower-priority buttons stay dropped.
          if (!p1_q[cur_idx] && !p2_q[cur_idx]) begin
            if (gs_q[0]) p2_d[cur_idx] = 1'b1;
            else         p1_d[cur_idx] = 1'b1;
            dir_d   = 2'd0;
            win_d   = 1'b0;
            state_d = StCheck;
          end
        end else if (btn_u) begin
          cy_d = (cy_q == '0) ? MAXC : cy_q - CW'(1);
        end else if (btn_d) begin
          cy_d = (cy_q == MAXC) ? '0 : cy_q + CW'(1);
        end else if (btn_l) begin
          cx_d = (cx_q == '0) ? MAXC : cx_q - CW'(1);
        end else if (btn_r) begin
          cx_d = (cx_q == MAXC) ? '0 : cx_q + CW'(1);
        end
      end
      StCheck: begin
        win_d = win_q | hit;
        dir_d = dir_q + 2'd1;
        if (dir_q == 2'd3) begin
          if (win_q | hit) begin
            gs_d    = gs_q[0] ? 3'd4 : 3'd3;
            games_d = sat_inc(games_q);
            if (gs_q[0]) p2w_d = sat_inc(p2w_q);
            else         p1w_d = sat_inc(p1w_q);
            state_d = StOver;
          end else if (&(p1_q | p2_q)) begin
            gs_d    = 3'd2;
            games_d = sat_inc(games_q);
            state_d = StOver;
          end else begin
            gs_d    = {2'b00, ~gs_q[0]};
            state_d = StPlay;
          end
        end
      end
      StOver: begin
        if (btn_s) begin
          p1_d      = '0;
          p2_d      = '0;
          cx_d      = '0;
          cy_d      = '0;
          starter_d = ~starter_q;
          gs_d      = {2'b00, ~starter_q};
          state_d   = StPlay;
        end
      end
      default: state_d = StPlay;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StPlay;
      cx_q      <= '0;
      cy_q      <= '0;
      p1_q      <= '0;
      p2_q      <= '0;
      gs_q      <= 3'd0;
      dir_q     <= 2'd0;
      win_q     <= 1'b0;
      starter_q <= 1'b0;
      games_q   <= 8'd0;
      p1w_q     <= 8'd0;
      p2w_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      gs_q      <= gs_d;
      dir_q     <= dir_d;
      win_q     <= win_d;
      starter_q <= starter_d;
      games_q   <= games_d;
      p1w_q     <= p1w_d;
      p2w_q     <= p2w_d;
    end
  end

  assign cursor_x     = cx_q;
  assign cursor_y     = cy_q;
  assign p1_grid      = p1_q;
  assign p2_grid      = p2_q;
  assign game_state   = gs_q;
  assign busy         = (state_q == StCheck);
  assign games_played = games_q;
  assign p1_wins      = p1w_q;
  assign p2_wins      = p2w_q;

endmodule

// File: tb/tb_ttt_grid_manager.sv
// Directed bench for ttt_grid_manager: a 3x3/3 instance (a) and a 5x5/4 instance (b).
module tb_ttt_grid_manager;

  localparam logic [4:0] S = 5'b10000, U = 5'b01000, D = 5'b00100, L = 5'b00010, R = 5'b00001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [4:0] btn_a, btn_b;

  logic [1:0] ax, ay;
  logic [8:0] ap1, ap2;
  logic [2:0] ags;
  logic       abusy;
  logic [7:0] agp, a1w, a2w;

  logic [2:0]  bx, by;
  logic [24:0] bp1, bp2;
  logic [2:0]  bgs;
  logic        bbusy;
  logic [7:0]  bgp, b1w, b2w;

  ttt_grid_manager #(.DIM(3), .WIN_LEN(3)) u_dut_a (
    .clk(clk), .rst(rst_a),
    .btn_s(btn_a[4]), .btn_u(btn_a[3]), .btn_d(btn_a[2]), .btn_l(btn_a[1]), .btn_r(btn_a[0]),
    .cursor_x(ax), .cursor_y(ay), .p1_grid(ap1), .p2_grid(ap2), .game_state(ags),
    .busy(abusy), .games_played(agp), .p1_wins(a1w), .p2_wins(a2w)
  );

  ttt_grid_manager #(.DIM(5), .WIN_LEN(4)) u_dut_b (
    .clk(clk), .rst(rst_b),
    .btn_s(btn_b[4]), .btn_u(btn_b[3]), .btn_d(btn_b[2]), .btn_l(btn_b[1]), .btn_r(btn_b[0]),
    .cursor_x(bx), .cursor_y(by), .p1_grid(bp1), .p2_grid(bp2), .game_state(bgs),
    .busy(bbusy), .games_played(bgp), .p1_wins(b1w), .p2_wins(b2w)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cx[2]    = '{0, 0};
  int cy[2]    = '{0, 0};
  int dim[2]   = '{3, 5};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle pulse sampled by the posedge between two negedges.
  task automatic press(input int sel, input logic [4:0] b);
    @(negedge clk);
    if (sel == 0) btn_a = b;
    else          btn_b = b;
    @(negedge clk);
    btn_a = '0;
    btn_b = '0;
  endtask

  task automatic move(input int sel, input logic [4:0] b);
    press(sel, b);
    if (b == U) cy[sel] = (cy[sel] + dim[sel] - 1) % dim[sel];
    if (b == D) cy[sel] = (cy[sel] + 1) % dim[sel];
    if (b == L) cx[sel] = (cx[sel] + dim[sel] - 1) % dim[sel];
    if (b == R) cx[sel] = (cx[sel] + 1) % dim[sel];
  endtask

  task automatic goto(input int sel, input int tx, input int ty);
    while (cx[sel] != tx) move(sel, R);
    while (cy[sel] != ty) move(sel, D);
  endtask

  // Placement: busy high for 4 samples with game_state held at the mover, then low.
  task automatic place(input int sel, input logic [4:0] b, input int mover, input bit chk);
    press(sel, b);
    for (int i = 0; i < 4; i++) begin
      if (chk) begin
        check($sformatf("busy_hi%0d", i), (sel == 0) ? abusy : bbusy, 1);
        check($sformatf("gs_hold%0d", i), (sel == 0) ? ags : bgs, mover);
      end
      @(negedge clk);
    end
    if (chk) check("busy_lo", (sel == 0) ? abusy : bbusy, 0);
  endtask

  task automatic new_game(input int sel);
    press(sel, S);
    cx[sel] = 0;
    cy[sel] = 0;
  endtask

  initial begin
    btn_a = '0;
    btn_b = '0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #12;
    check("rst_cx", ax, 0);
    check("rst_cy", ay, 0);
    check("rst_p1", ap1, 0);
    check("rst_p2", ap2, 0);
    check("rst_gs", ags, 0);
    check("rst_busy", abusy, 0);
    check("rst_gp", agp, 0);
    check("rst_w1", a1w, 0);
    check("rst_w2", a2w, 0);
    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Cursor wrap on both axes
    move(0, L);
    @(negedge clk);
    check("wrap_x", {ay, ax}, {2'd0, 2'd2});
    move(0, U);
    @(negedge clk);
    check("wrap_xy", {ay, ax}, {2'd2, 2'd2});

    // Game 1: P1 wins on the top row
    goto(0, 0, 0); place(0, S, 0, 1);
    check("g1_turn1", ags, 1);
    goto(0, 0, 1); place(0, S, 1, 1);
    check("g1_turn2", ags, 0);
    goto(0, 1, 0); place(0, S, 0, 1);
    goto(0, 1, 1); place(0, S, 1, 1);
    goto(0, 2, 0); place(0, S, 0, 1);
    check("g1_gs", ags, 3);
    check("g1_p1", ap1, 9'b000000111);
    check("g1_p2", ap2, 9'b000011000);
    check("g1_w1", a1w, 1);
    check("g1_w2", a2w, 0);
    check("g1_gp", agp, 1);
    press(0, R);
    check("over_nomove", {ay, ax}, {2'd0, 2'd2});
    new_game(0);
    check("ng1_gs", ags, 1);
    check("ng1_grids", {ap2, ap1}, 0);
    check("ng1_cur", {ay, ax}, 0);

    // Game 2: P2 starts; occupied press; s+r together; ends in a draw
    place(0, S, 1, 1);
    press(0, S);
    check("occ_busy", abusy, 0);
    check("occ_p1", ap1, 0);
    check("occ_p2", ap2, 9'b000000001);
    check("occ_gs", ags, 0);
    goto(0, 1, 0); place(0, S | R, 0, 1);
    check("sr_cur", {ay, ax}, {2'd0, 2'd1});
    check("sr_p1", ap1, 9'b000000010);
    goto(0, 2, 0); place(0, S, 1, 1);
    goto(0, 1, 1); place(0, S, 0, 1);
    goto(0, 0, 1); place(0, S, 1, 1);
    goto(0, 2, 1); place(0, S, 0, 1);
    goto(0, 1, 2); place(0, S, 1, 1);
    goto(0, 0, 2); place(0, S, 0, 1);
    goto(0, 2, 2); place(0, S, 1, 1);
    check("draw_gs", ags, 2);
    check("draw_gp", agp, 2);
    check("draw_w1", a1w, 1);
    check("draw_w2", a2w, 0);
    check("draw_p1", ap1, 9'b001110010);
    check("draw_p2", ap2, 9'b110001101);
    new_game(0);
    check("ng2_gs", ags, 0);
    check("ng2_grids", {ap2, ap1}, 0);

    // Asynchronous reset in the middle of CHECK
    goto(0, 1, 1);
    press(0, S);
    check("mid_busy", abusy, 1);
    #2;
    rst_a = 1'b0;
    #1;
    check("arst_cur", {ay, ax}, 0);
    check("arst_grids", {ap2, ap1}, 0);
    check("arst_gs", ags, 0);
    check("arst_busy", abusy, 0);
    check("arst_cnt", {agp, a1w, a2w}, 0);
    @(negedge clk);
    rst_a = 1'b1;
    cx[0] = 0;
    cy[0] = 0;

    // 256 quick games, the starter always wins its top row
    for (int g = 0; g < 256; g++) begin
      int s;
      s = g % 2;
      goto(0, 0, 0); place(0, S, s, 0);
      goto(0, 0, 1); place(0, S, 1 - s, 0);
      goto(0, 1, 0); place(0, S, s, 0);
      goto(0, 1, 1); place(0, S, 1 - s, 0);
      goto(0, 2, 0); place(0, S, s, 0);
      check($sformatf("bulk_gs%0d", g), ags, (s == 0) ? 3 : 4);
      if (g == 254) check("gp_255", agp, 255);
      new_game(0);
    end
    check("gp_sat", agp, 255);
    check("bulk_w1", a1w, 128);
    check("bulk_w2", a2w, 128);

    // 5x5, WIN_LEN=4: P2 anti-diagonal win
    goto(1, 0, 0); place(1, S, 0, 1);
    goto(1, 4, 0); place(1, S, 1, 1);
    goto(1, 1, 0); place(1, S, 0, 1);
    goto(1, 3, 1); place(1, S, 1, 1);
    goto(1, 0, 4); place(1, S, 0, 1);
    goto(1, 2, 2); place(1, S, 1, 1);
    goto(1, 4, 4); place(1, S, 0, 1);
    goto(1, 1, 3); place(1, S, 1, 1);
    check("b_gs", bgs, 4);
    check("b_w2", b2w, 1);
    check("b_w1", b1w, 0);
    check("b_gp", bgp, 1);
    new_game(1);
    check("b_ng_gs", bgs, 1);

    // Three in a row against the right edge; (0,1) follows (4,0) in flat order only
    goto(1, 0, 1); place(1, S, 1, 1);
    goto(1, 0, 3); place(1, S, 0, 1);
    goto(1, 2, 0); place(1, S, 1, 1);
    goto(1, 1, 3); place(1, S, 0, 1);
    goto(1, 3, 0); place(1, S, 1, 1);
    goto(1, 0, 4); place(1, S, 0, 1);
    goto(1, 4, 0); place(1, S, 1, 1);
    check("edge_gs", bgs, 0);
    check("edge_w2", b2w, 1);
    check("edge_gp", bgp, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
